// File: rtl/johnson_seq_ctrl.sv
// Purpose : step controller for an N-stage Johnson ring (2N-phase sequencer) with
//           hold/abort, one-hot phase decode and illegal-state recovery.
// Latency : command accepted at edge k steps at edges k+1..k+steps; o_done in the cycle after.
// Backpr. : o_cmd_ready only in IDLE; i_hold freezes stepping 1:1 and i_abort drops the command.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready, i_cmd_steps, i_cmd_dir   step command handshake (dir 1 = reverse)
//   i_hold, i_abort       freeze / terminate a running command
//   i_ld, i_ld_q          preset the ring while idle
//   o_q                   ring state (MSB = o_q[N_STAGES-1])
//   o_phase, o_phase_idx  one-hot phase and forward phase index, decoded from o_q
//   o_busy, o_done, o_err running, completion pulse, illegal-state pulse

module johnson_seq_ctrl #(
   parameter int N_STAGES = 3,
   parameter int CNT_W    = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [CNT_W-1:0]              i_cmd_steps,
   input  logic                          i_cmd_dir,
   input  logic                          i_hold,
   input  logic                          i_abort,
   input  logic                          i_ld,
   input  logic [N_STAGES-1:0]           i_ld_q,
   output logic [N_STAGES-1:0]           o_q,
   output logic [2*N_STAGES-1:0]         o_phase,
   output logic [$clog2(2*N_STAGES)-1:0] o_phase_idx,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_err
);

   localparam int PH_W  = 2 * N_STAGES;
   localparam int IDX_W = $clog2(PH_W);

   // One-hot encoding so the handshake/status outputs come straight off state flops.
   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_RUN  = 5'b00010,
      S_HOLD = 5'b00100,
      S_DONE = 5'b01000,
      S_ERR  = 5'b10000
   } state_t;

   state_t              state;
   logic [N_STAGES-1:0] q;
   logic [N_STAGES-1:0] q_fwd;
   logic [N_STAGES-1:0] q_rev;
   logic [N_STAGES-1:0] q_step;
   logic [CNT_W-1:0]    rem;
   logic                dir;
   logic                legal;
   logic [IDX_W-1:0]    idx;

   // ------------------------------------------------------------------
   // Next ring value in either direction
   // ------------------------------------------------------------------
   assign q_fwd  = {~q[0], q[N_STAGES-1:1]};
   assign q_rev  = {q[N_STAGES-2:0], ~q[N_STAGES-1]};
   assign q_step = dir ? q_rev : q_fwd;

   // ------------------------------------------------------------------
   // Legality: a Johnson state has at most one transition between
   // neighbouring bits (0..01..1 or 1..10..0).
   // ------------------------------------------------------------------
   always_comb begin : legal_chk
      int edges;
      edges = 0;
      for (int i = 0; i < N_STAGES - 1; i++) begin
         if (q[i] != q[i+1]) edges++;
      end
      legal = (edges <= 1);
   end

   // ------------------------------------------------------------------
   // Phase index. With q[0]==0 the ring is filling with ones from the MSB,
   // so the index is the count of ones; with q[0]==1 it is draining, so the
   // index is N plus the count of zeros. Illegal states decode to index 0.
   // ------------------------------------------------------------------
   always_comb begin : idx_dec
      int ones;
      ones = 0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (q[i]) ones++;
      end
      if (!legal)
         idx = '0;
      else if (!q[0])
         idx = IDX_W'(ones);
      else
         idx = IDX_W'(2 * N_STAGES - ones);
   end

   assign o_q         = q;
   assign o_phase_idx = idx;
   assign o_phase     = legal ? (PH_W'(1) << idx) : '0;

   assign o_cmd_ready = state[0];
   assign o_busy      = state[1] | state[2];
   assign o_done      = state[3];
   assign o_err       = state[4];

   // ------------------------------------------------------------------
   // Sequencer FSM. Priority: reset > illegal ring > abort > hold > step.
   // A hold cycle replaces exactly one step: the edge on which i_hold is
   // seen low again (in HOLD) already steps, so the latency grows 1:1.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
         q     <= '0;
         rem   <= '0;
         dir   <= 1'b0;
      end else if (state != S_ERR && !legal) begin
         // Ring is left as-is; it is cleared on the way out of ERR.
         state <= S_ERR;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  dir   <= i_cmd_dir;
                  rem   <= i_cmd_steps;
                  state <= (i_cmd_steps == '0) ? S_DONE : S_RUN;
               end else if (i_ld) begin
                  q <= i_ld_q;
               end
            end
            S_RUN, S_HOLD: begin
               if (i_abort) begin
                  state <= S_IDLE;
               end else if (i_hold) begin
                  state <= S_HOLD;
               end else begin
                  q     <= q_step;
                  rem   <= rem - CNT_W'(1);
                  state <= (rem == CNT_W'(1)) ? S_DONE : S_RUN;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            S_ERR: begin
               q     <= '0;
               rem   <= '0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
